uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Serial front end for the register block: receives 8N1 UART bytes on a single input line, decodes a one- or two-byte command protocol, and drives the register block's `data_in`/`read`/`write` handshake. Read results returned on the register block's `data_out`/`valid` are captured and presented as a one-cycle strobe for a downstream UART transmitter.

## Interface
- `CLK_DIV`, 434: clock cycles per bit (50 MHz / 115200 baud); must be ≥ 8.
- `TIMEOUT`, 8: cycles to wait for `reg_valid` after raising `reg_read`.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  UART line, idle high, asynchronous to `clk`.
- `reg_data`  out  8  to register block `data_in`; carries address, then write data.
- `reg_read`  out  1  to register block `read`.
- `reg_write`  out  1  to register block `write`.
- `reg_rdata`  in  8  from register block `data_out`.
- `reg_valid`  in  1  from register block `valid`.
- `rd_data`  out  8  last read result.
- `rd_strobe`  out  1  one-cycle pulse, `rd_data` newly valid.
- `err`  out  1  one-cycle pulse on framing error, bad command, or read timeout.
- `busy`  out  1  high whenever the command FSM is not in IDLE.

## Operation
- Reset: all outputs 0; rx synchroniser flops reset to 1; both FSMs to idle states.
- RX path: `rx` through a 2-flop synchroniser. RX states R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: synchronised low → R_START, bit counter loaded with CLK_DIV/2 (integer division).
  - R_START: at count end, line still low → R_DATA; line high → R_IDLE (glitch, no `err`).
  - R_DATA: sample every CLK_DIV cycles, 8 bits LSB first into shift register.
  - R_STOP: sample after CLK_DIV; 1 → one-cycle internal `byte_done`; 0 → `err` pulse, byte discarded. Either way → R_IDLE in the same cycle, ready for the next start edge.
- Command byte: bit 7 = 1 write, 0 read; bits 6:4 must be 000; bits 3:0 address. Address 0xF or nonzero bits 6:4 → `err`, byte ignored (register block only accepts addresses 0–14).
- Command FSM states: IDLE, WR_WAIT, WR_ADDR, WR_DATA, RD_REQ, RD_REL.
  - IDLE + valid read command → RD_REQ: `reg_data`=address, `reg_read`=1.
  - RD_REQ: `reg_valid`=1 → `rd_data`←`reg_rdata`, `rd_strobe`=1, `reg_read`=0, → RD_REL. TIMEOUT cycles with no `reg_valid` → `reg_read`=0, `err`, → RD_REL.
  - RD_REL: wait for `reg_valid`=0, then → IDLE.
  - IDLE + valid write command → WR_WAIT, address latched.
  - WR_WAIT + `byte_done` → data latched, → WR_ADDR.
  - WR_ADDR (1 cycle): `reg_data`=address, `reg_write`=1 → WR_DATA.
  - WR_DATA (1 cycle): `reg_data`=data, `reg_write`=0 → IDLE. The register block stores `reg_data` in this cycle.
- `reg_read` and `reg_write` are never high together.
- `reg_data` holds its last value in IDLE.
- `byte_done` in WR_ADDR/WR_DATA/RD_REQ/RD_REL: byte dropped, `err` pulses.
- WR_WAIT has no timeout; only reset or a following byte exits it.

## Timing
- `byte_done` at cycle N. Read: `reg_read` high from N+1; register raises `valid` at N+2; `rd_strobe` high in N+3, `reg_read` low from N+3; IDLE once `reg_valid` seen low (nominally N+5).
- Write: `byte_done` of data byte at N. `reg_write`=1 with address in N+1; data with `reg_write`=0 in N+2; IDLE at N+3.
- Bit sampling at start edge + 2 (sync) + CLK_DIV/2 + k·CLK_DIV, k=1..9; k=9 is stop.
- `rd_strobe` and `err` are exactly one cycle wide; `busy` rises the cycle after the command byte's `byte_done`.
- `rst` mid-frame or mid-handshake: all outputs 0 immediately. Partial byte and pending write are lost. First start edge after release is received normally.

## Test plan
- CLK_DIV=16. Send 0x83, 0x5A → WR_ADDR cycle `reg_data`=0x03 `reg_write`=1, next cycle `reg_data`=0x5A `reg_write`=0; reg 3 = 0x5A.
- Then send 0x03 → `reg_read` 2 cycles, `rd_strobe` with `rd_data`=0x5A, `busy` low 2 cycles later.
- Send 0x0F, then 0x93 → two `err` pulses, no `reg_read`/`reg_write` activity.
- Frame 0x41 with stop bit forced 0 → `err` pulse, no command. Then valid 0x01 → normal read of reg 1.
- Hold `reg_valid`=0 (stub), send 0x02 → `reg_read` high exactly 8 cycles, then `err`, no `rd_strobe`.
- Assert `rst` during bit 4 of 0x85 → outputs 0. Then full 0x85, 0x11 → reg 5 = 0x11. Also a 3-cycle low glitch on idle `rx` → no `byte_done`, no `err`.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver with one/two-byte register command decoder
module uart_cmd_rx #(
  parameter int CLK_DIV = 434,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] reg_data,
  output logic       reg_read,
  output logic       reg_write,
  input  logic [7:0] reg_rdata,
  input  logic       reg_valid,
  output logic [7:0] rd_data,
  output logic       rd_strobe,
  output logic       err,
  output logic       busy
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_ADDR, WR_DATA, RD_REQ, RD_REL} cmd_state_t;

  rx_state_t  r_state, r_next;
  cmd_state_t c_state, c_next;

  logic          rx_s1, rx_s2;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_done, frame_err;
  logic          cnt_end;

  logic [3:0]    addr;
  logic [7:0]    wdata;
  logic [TW-1:0] tcnt;
  logic          cmd_ok, tmo;
  logic [7:0]    data_nxt;
  logic          strobe_nxt, err_nxt;

  assign cnt_end = (cnt == '0);

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // RX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // RX next state: half-bit to mid start bit, then one bit period per sample
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (!rx_s2) r_next = R_START;
      R_START: if (cnt_end) r_next = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (cnt_end && bit_idx == 3'd7) r_next = R_STOP;
      R_STOP:  if (cnt_end) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // RX outputs: stop-bit sample decides between a good byte and a framing error
  always_comb begin
    byte_done = (r_state == R_STOP) && cnt_end && rx_s2;
    frame_err = (r_state == R_STOP) && cnt_end && !rx_s2;
  end

  // RX datapath: bit-period counter, bit index and LSB-first shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      case (r_state)
        R_IDLE: begin
          cnt     <= HALF_M1;
          bit_idx <= 3'd0;
        end
        R_START: cnt <= cnt_end ? FULL_M1 : cnt - 1'b1;
        R_DATA: begin
          if (cnt_end) begin
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            cnt     <= FULL_M1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_STOP: if (!cnt_end) cnt <= cnt - 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // Register block only decodes addresses 0-14 and bits 6:4 are reserved
  assign cmd_ok = (shreg[6:4] == 3'b000) && (shreg[3:0] != 4'hF);
  assign tmo    = (c_state == RD_REQ) && !reg_valid && (tcnt == TO_LAST);

  // Command state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) c_state <= IDLE;
    else     c_state <= c_next;
  end

  // Command next state
  always_comb begin
    c_next = c_state;
    case (c_state)
      IDLE:    if (byte_done && cmd_ok) c_next = shreg[7] ? WR_WAIT : RD_REQ;
      WR_WAIT: if (byte_done) c_next = WR_ADDR;
      WR_ADDR: c_next = WR_DATA;
      WR_DATA: c_next = IDLE;
      RD_REQ:  if (reg_valid || tmo) c_next = RD_REL;
      RD_REL:  if (!reg_valid) c_next = IDLE;
      default: c_next = IDLE;
    endcase
  end

  // Command outputs: handshake levels from state, registered values prepared here
  always_comb begin
    reg_read   = (c_state == RD_REQ);
    reg_write  = (c_state == WR_ADDR);
    busy       = (c_state != IDLE);
    strobe_nxt = (c_state == RD_REQ) && reg_valid;
    err_nxt    = frame_err || tmo ||
                 (byte_done && (((c_state == IDLE) && !cmd_ok) ||
                  (c_state inside {WR_ADDR, WR_DATA, RD_REQ, RD_REL})));
    data_nxt   = reg_data;
    if (c_state == IDLE && byte_done && cmd_ok && !shreg[7]) data_nxt = {4'h0, shreg[3:0]};
    else if (c_state == WR_WAIT && byte_done)                data_nxt = {4'h0, addr};
    else if (c_state == WR_ADDR)                             data_nxt = wdata;
  end

  // Command datapath: latched address/data, read timeout, registered pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= 4'h0;
      wdata     <= 8'h00;
      tcnt      <= '0;
      reg_data  <= 8'h00;
      rd_data   <= 8'h00;
      rd_strobe <= 1'b0;
      err       <= 1'b0;
    end else begin
      reg_data  <= data_nxt;
      rd_strobe <= strobe_nxt;
      err       <= err_nxt;
      tcnt      <= (c_state == RD_REQ) ? tcnt + 1'b1 : '0;
      if (strobe_nxt) rd_data <= reg_rdata;
      if (c_state == IDLE && byte_done) addr <= shreg[3:0];
      if (c_state == WR_WAIT && byte_done) wdata <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - directed bench for uart_cmd_rx with a register-block stub
module tb_uart_cmd_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] reg_data;
  logic       reg_read, reg_write;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_valid = 1'b0;
  logic [7:0] rd_data;
  logic       rd_strobe, err, busy;

  logic       stub_en = 1'b1;
  logic [7:0] mem [0:14] = '{8'h00, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic       wr_d = 1'b0;
  logic [3:0] wa = 4'h0;

  int n_checks = 0;
  int n_pass = 0;

  int cyc = 0;
  int rd_cycles, wr_cycles, strobe_cnt, err_cnt, busy_cycles;
  int strobe_cyc, err_cyc, last_rd_cyc, busy_fall_cyc;
  int overlap = 0;
  int wide = 0;
  logic [7:0] last_rd, wr_addr_seen, wr_data_seen;
  logic wr_follow;
  logic prev_wr = 1'b0, prev_strobe = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;

  uart_cmd_rx #(.CLK_DIV(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .reg_data(reg_data), .reg_read(reg_read), .reg_write(reg_write),
    .reg_rdata(reg_rdata), .reg_valid(reg_valid),
    .rd_data(rd_data), .rd_strobe(rd_strobe), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register block: valid one cycle after read, stores data the cycle after write
  always @(posedge clk) begin
    reg_valid <= reg_read && stub_en;
    if (reg_read && reg_data[3:0] != 4'hF) reg_rdata <= mem[reg_data[3:0]];
    if (wr_d && wa != 4'hF) mem[wa] <= reg_data;
    wr_d <= reg_write;
    if (reg_write) wa <= reg_data[3:0];
  end

  // Activity monitor sampled away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reg_read) begin rd_cycles = rd_cycles + 1; last_rd_cyc = cyc; end
    if (reg_write) begin wr_cycles = wr_cycles + 1; wr_addr_seen = reg_data; end
    if (prev_wr) begin wr_data_seen = reg_data; wr_follow = reg_write; end
    prev_wr = reg_write;
    if (reg_read && reg_write) overlap = overlap + 1;
    if (rd_strobe) begin
      strobe_cnt = strobe_cnt + 1; last_rd = rd_data; strobe_cyc = cyc;
      if (prev_strobe) wide = wide + 1;
    end
    prev_strobe = rd_strobe;
    if (err) begin
      err_cnt = err_cnt + 1; err_cyc = cyc;
      if (prev_err) wide = wide + 1;
    end
    prev_err = err;
    if (busy) busy_cycles = busy_cycles + 1;
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_busy = busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_counts();
    rd_cycles = 0; wr_cycles = 0; strobe_cnt = 0; err_cnt = 0; busy_cycles = 0;
    strobe_cyc = 0; err_cyc = 0; last_rd_cyc = 0; busy_fall_cyc = 0;
    last_rd = 8'h00; wr_addr_seen = 8'h00; wr_data_seen = 8'h00; wr_follow = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_ok;
    repeat (stop_ok ? 16 : 12) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_reg_data"}, reg_data, 8'h00);
    check({tag, "_reg_read"}, reg_read, 1'b0);
    check({tag, "_reg_write"}, reg_write, 1'b0);
    check({tag, "_rd_data"}, rd_data, 8'h00);
    check({tag, "_rd_strobe"}, rd_strobe, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] partial;
    clear_counts();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");

    // Write 0x5A to register 3
    clear_counts();
    send(8'h83, 1'b1);
    check("wr_wait_busy", busy, 1'b1);
    send(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    check("wr_cycles", wr_cycles, 1);
    check("wr_addr", wr_addr_seen, 8'h03);
    check("wr_data", wr_data_seen, 8'h5A);
    check("wr_data_write_low", wr_follow, 1'b0);
    check("mem3", mem[3], 8'h5A);
    check("wr_err", err_cnt, 0);

    // Read register 3 back
    clear_counts();
    send(8'h03, 1'b1);
    repeat (20) @(negedge clk);
    check("rd_cycles", rd_cycles, 2);
    check("rd_strobes", strobe_cnt, 1);
    check("rd_data3", last_rd, 8'h5A);
    check("busy_after_strobe", busy_fall_cyc - strobe_cyc, 2);
    check("rd_err", err_cnt, 0);

    // Bad address and reserved bits
    clear_counts();
    send(8'h0F, 1'b1);
    send(8'h93, 1'b1);
    repeat (10) @(negedge clk);
    check("bad_cmd_err", err_cnt, 2);
    check("bad_cmd_rd", rd_cycles, 0);
    check("bad_cmd_wr", wr_cycles, 0);
    check("bad_cmd_busy", busy_cycles, 0);

    // Framing error, then a normal read of register 1
    clear_counts();
    send(8'h41, 1'b0);
    repeat (20) @(negedge clk);
    check("frame_err", err_cnt, 1);
    check("frame_busy", busy_cycles, 0);
    check("frame_rd", rd_cycles, 0);
    clear_counts();
    send(8'h01, 1'b1);
    repeat (20) @(negedge clk);
    check("rd1_strobes", strobe_cnt, 1);
    check("rd1_data", last_rd, 8'hC3);
    check("rd1_err", err_cnt, 0);

    // Read timeout with a silent register block
    clear_counts();
    stub_en = 1'b0;
    send(8'h02, 1'b1);
    repeat (20) @(negedge clk);
    stub_en = 1'b1;
    check("tmo_rd_cycles", rd_cycles, 8);
    check("tmo_err", err_cnt, 1);
    check("tmo_err_timing", err_cyc - last_rd_cyc, 1);
    check("tmo_strobe", strobe_cnt, 0);
    check("tmo_idle", busy, 1'b0);

    // Reset during bit 4 of 0x85
    partial = 8'h85;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      repeat (16) @(negedge clk);
    end
    rx = partial[4];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    clear_counts();
    send(8'h85, 1'b1);
    send(8'h11, 1'b1);
    repeat (10) @(negedge clk);
    check("post_rst_mem5", mem[5], 8'h11);
    check("post_rst_wr_addr", wr_addr_seen, 8'h05);
    check("post_rst_err", err_cnt, 0);

    // Short low glitch on idle line
    clear_counts();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_err", err_cnt, 0);
    check("glitch_busy", busy_cycles, 0);

    check("read_write_overlap", overlap, 0);
    check("pulse_width", wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
